// File: rtl/rooth_test_seq_monitor_if.sv
// Register-file write-back port of the rooth core, as seen by the test monitor.
// Latency: none, plain wires.
// Backpressure: none; the monitor only observes, the core always drives.
interface rooth_test_seq_monitor_if #(
  parameter int XLEN = 32
) ();
  logic            wb_we;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;

  modport master (output wb_we, wb_addr, wb_data);
  modport slave  (input  wb_we, wb_addr, wb_data);
endinterface

// File: rtl/rooth_test_seq_monitor.sv
// Steps the rooth core through NUM_TESTS test images and judges each from register write-back traffic.
// Latency: core_rst_n/load_req/busy follow the state directly; verdicts and counters register on the cycle SETTLE ends.
// Backpressure: none; write-back is observed only, start is ignored while busy, abort wins over all but rst_n.
module rooth_test_seq_monitor #(
  parameter int XLEN           = 32,
  parameter int NUM_TESTS      = 45,
  parameter int IDX_W          = 6,
  parameter int DONE_REG       = 26,
  parameter int PASS_REG       = 27,
  parameter int TESTNUM_REG    = 3,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int RST_CYCLES     = 1,
  parameter int SETTLE_CYCLES  = 1,
  parameter int CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  rooth_test_seq_monitor_if.slave wb,
  output logic                 core_rst_n,
  output logic                 load_req,
  output logic [IDX_W-1:0]     test_idx,
  output logic                 busy,
  output logic                 test_pass_p,
  output logic                 test_fail,
  output logic                 test_timeout,
  output logic                 all_done,
  output logic [XLEN-1:0]      fail_testnum,
  output logic [IDX_W:0]       pass_cnt,
  output logic [CNT_W-1:0]     cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_SETTLE, S_FAIL, S_TIMEOUT, S_ALL_DONE
  } state_t;

  localparam logic [4:0]      DONE_A    = 5'(DONE_REG);
  localparam logic [4:0]      PASS_A    = 5'(PASS_REG);
  localparam logic [4:0]      TNUM_A    = 5'(TESTNUM_REG);
  localparam logic [XLEN-1:0] ONE       = XLEN'(1);
  localparam logic [31:0]     LOAD_LAST = 32'(RST_CYCLES - 1);
  localparam logic [31:0]     SETL_LAST = 32'(SETTLE_CYCLES - 1);
  // Compared at 64 bits so a budget beyond 2^CNT_W simply never fires.
  localparam logic [63:0]     TO_LAST   = 64'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_TESTS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W:0]   PCNT_ONE = (IDX_W+1)'(1);
  localparam logic [CNT_W-1:0] CYC_ONE  = CNT_W'(1);

  state_t          state_q, state_d;
  logic [31:0]     phase_cnt;
  logic            pass_flag;
  logic [XLEN-1:0] testnum;

  logic wr_ok, done_wr, tn_wr, pf_wr;
  logic load_last, settle_last, timeout_hit, last_test;

  assign wr_ok       = wb.wb_we && (wb.wb_addr != 5'd0);
  assign done_wr     = wr_ok && (wb.wb_addr == DONE_A) && (wb.wb_data == ONE);
  assign tn_wr       = wr_ok && (wb.wb_addr == TNUM_A);
  assign pf_wr       = wr_ok && (wb.wb_addr == PASS_A);
  assign load_last   = (phase_cnt == LOAD_LAST);
  assign settle_last = (phase_cnt == SETL_LAST);
  assign timeout_hit = (64'(cycle_cnt) == TO_LAST);
  assign last_test   = (test_idx == IDX_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decision and the state-decoded outputs.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:   if (load_last) state_d = S_RUN;
      S_RUN: begin
        if (done_wr)          state_d = S_SETTLE;
        else if (timeout_hit) state_d = S_TIMEOUT;
      end
      S_SETTLE: begin
        if (settle_last) begin
          if (!pass_flag)     state_d = S_FAIL;
          else if (last_test) state_d = S_ALL_DONE;
          else                state_d = S_LOAD;
        end
      end
      default:  if (start) state_d = S_LOAD;
    endcase
    if (abort) state_d = S_IDLE;

    core_rst_n = (state_q == S_RUN) || (state_q == S_SETTLE);
    busy       = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_SETTLE);
    load_req   = (state_q == S_LOAD) && (phase_cnt == 32'd0) && !abort;
  end

  // Phase timer: cycles spent in the current state, restarted on every transition.
  always_ff @(posedge clk) begin
    if (!rst_n || (state_d != state_q)) phase_cnt <= 32'd0;
    else                                phase_cnt <= phase_cnt + 32'd1;
  end

  // Suite bookkeeping, per-test capture and verdicts; abort freezes all of it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      test_idx     <= '0;
      test_pass_p  <= 1'b0;
      test_fail    <= 1'b0;
      test_timeout <= 1'b0;
      all_done     <= 1'b0;
      fail_testnum <= '0;
      pass_cnt     <= '0;
      cycle_cnt    <= '0;
      pass_flag    <= 1'b0;
      testnum      <= '0;
    end else begin
      test_pass_p <= 1'b0;
      if (!abort) begin
        case (state_q)
          S_LOAD: begin
            pass_flag <= 1'b0;
            testnum   <= '0;
            cycle_cnt <= '0;
          end
          S_RUN: begin
            if (cycle_cnt != {CNT_W{1'b1}}) cycle_cnt <= cycle_cnt + CYC_ONE;
            if (tn_wr) testnum   <= wb.wb_data;
            if (pf_wr) pass_flag <= (wb.wb_data == ONE);
            if (!done_wr && timeout_hit) begin
              test_timeout <= 1'b1;
              fail_testnum <= testnum;
            end
          end
          S_SETTLE: begin
            // The verdict uses the flag as registered; a write on the last cycle is too late.
            if (tn_wr) testnum   <= wb.wb_data;
            if (pf_wr) pass_flag <= (wb.wb_data == ONE);
            if (settle_last) begin
              if (pass_flag) begin
                test_pass_p <= 1'b1;
                pass_cnt    <= pass_cnt + PCNT_ONE;
                if (last_test) all_done <= 1'b1;
                else           test_idx <= test_idx + IDX_ONE;
              end else begin
                test_fail    <= 1'b1;
                fail_testnum <= testnum;
              end
            end
          end
          default: begin
            if (start) begin
              test_idx     <= '0;
              pass_cnt     <= '0;
              test_fail    <= 1'b0;
              test_timeout <= 1'b0;
              all_done     <= 1'b0;
              fail_testnum <= '0;
            end
          end
        endcase
      end
    end
  end

endmodule
